// File: rtl/coin_hopper_ctrl.sv
// Coin hopper controller: queues 5c/10c change requests, drives one hopper motor at a time,
// tracks per-denomination inventory, substitutes two 5c coins for a 10c coin when needed, and detects jams.
module coin_hopper_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned INIT_INV       = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       change_5C,
    input  logic       change_10C,
    input  logic       coin_sensed_5C,
    input  logic       coin_sensed_10C,
    input  logic       refill_5C,
    input  logic       refill_10C,
    input  logic [7:0] refill_count,
    input  logic       jam_clear,
    output logic       eject_5C,
    output logic       eject_10C,
    output logic       busy,
    output logic       jam,
    output logic       out_of_change,
    output logic       req_drop
);

    localparam int unsigned   TW     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EJECT10,
        S_EJECT5,
        S_GAP,
        S_JAM
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [3:0]    pend_5, pend_10, pend_5_n, pend_10_n;
    logic [7:0]    inv_5, inv_10, inv_5_n, inv_10_n;
    logic          svc5, svc10, sub, ooc_n;
    logic          drop5, drop10;
    logic [5:0]    sum5, sum10;

    always_comb begin
        state_n   = state;
        tcnt_n    = tcnt;
        svc5      = 1'b0;
        svc10     = 1'b0;
        sub       = 1'b0;
        ooc_n     = 1'b0;
        sum5      = '0;
        sum10     = '0;
        drop5     = 1'b0;
        drop10    = 1'b0;
        pend_5_n  = pend_5;
        pend_10_n = pend_10;
        inv_5_n   = inv_5;
        inv_10_n  = inv_10;

        case (state)
            S_IDLE: begin
                if (pend_10 != 4'd0 && inv_10 != 8'd0) begin
                    state_n = S_EJECT10;
                    tcnt_n  = '0;
                end else if (pend_10 != 4'd0 && inv_5 >= 8'd2) begin
                    // No 10c coins left: convert one 10c request into two 5c requests.
                    sub = 1'b1;
                end else if (pend_5 != 4'd0 && inv_5 != 8'd0) begin
                    state_n = S_EJECT5;
                    tcnt_n  = '0;
                end else begin
                    ooc_n = (pend_5 != 4'd0) || (pend_10 != 4'd0);
                end
            end
            S_EJECT10: begin
                if (coin_sensed_10C) begin
                    svc10   = (pend_10 != 4'd0);
                    state_n = S_GAP;
                end else if (tcnt == T_LAST) begin
                    state_n = S_JAM;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            S_EJECT5: begin
                if (coin_sensed_5C) begin
                    svc5    = (pend_5 != 4'd0);
                    state_n = S_GAP;
                end else if (tcnt == T_LAST) begin
                    state_n = S_JAM;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            S_GAP: state_n = S_IDLE;
            S_JAM: begin
                if (jam_clear) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Widened arithmetic so a request landing on a full counter is visible as overflow.
        sum5      = 6'(pend_5) + 6'(change_5C) + (sub ? 6'd2 : 6'd0) - 6'(svc5);
        sum10     = 6'(pend_10) + 6'(change_10C) - 6'(svc10) - 6'(sub);
        drop5     = (sum5 > 6'd15);
        drop10    = (sum10 > 6'd15);
        pend_5_n  = drop5 ? 4'd15 : sum5[3:0];
        pend_10_n = drop10 ? 4'd15 : sum10[3:0];

        if (svc5 && inv_5 != 8'd0) begin
            inv_5_n = inv_5 - 8'd1;
        end
        if (svc10 && inv_10 != 8'd0) begin
            inv_10_n = inv_10 - 8'd1;
        end
        if (refill_5C) begin
            inv_5_n = refill_count;
        end
        if (refill_10C) begin
            inv_10_n = refill_count;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= S_IDLE;
            tcnt          <= '0;
            pend_5        <= '0;
            pend_10       <= '0;
            inv_5         <= 8'(INIT_INV);
            inv_10        <= 8'(INIT_INV);
            eject_5C      <= 1'b0;
            eject_10C     <= 1'b0;
            jam           <= 1'b0;
            out_of_change <= 1'b0;
            req_drop      <= 1'b0;
        end else begin
            state         <= state_n;
            tcnt          <= tcnt_n;
            pend_5        <= pend_5_n;
            pend_10       <= pend_10_n;
            inv_5         <= inv_5_n;
            inv_10        <= inv_10_n;
            eject_5C      <= (state_n == S_EJECT5);
            eject_10C     <= (state_n == S_EJECT10);
            jam           <= (state_n == S_JAM);
            out_of_change <= ooc_n;
            req_drop      <= drop5 | drop10;
        end
    end

    assign busy = (state != S_IDLE) || (pend_5 != 4'd0) || (pend_10 != 4'd0);

endmodule

// File: tb/tb_coin_hopper_ctrl.sv
// Self-checking bench for coin_hopper_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the hopper.
module tb_coin_hopper_ctrl;

    localparam int TO  = 8;
    localparam int INV = 20;

    logic       clk;
    logic       rst;
    logic       change_5C, change_10C, coin_sensed_5C, coin_sensed_10C;
    logic       refill_5C, refill_10C, jam_clear;
    logic [7:0] refill_count;
    logic       eject_5C, eject_10C, busy, jam, out_of_change, req_drop;

    coin_hopper_ctrl #(.TIMEOUT_CYCLES(TO), .INIT_INV(INV)) dut (
        .clk(clk), .rst(rst),
        .change_5C(change_5C), .change_10C(change_10C),
        .coin_sensed_5C(coin_sensed_5C), .coin_sensed_10C(coin_sensed_10C),
        .refill_5C(refill_5C), .refill_10C(refill_10C), .refill_count(refill_count),
        .jam_clear(jam_clear),
        .eject_5C(eject_5C), .eject_10C(eject_10C), .busy(busy), .jam(jam),
        .out_of_change(out_of_change), .req_drop(req_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    // Model: hopper activity (0 waiting, 1 dispensing, 2 settling, 3 stuck) and coin bookkeeping.
    int m_p5, m_p10, m_i5, m_i10, m_activity, m_coin, m_since;
    int e_ej5, e_ej10, e_busy, e_jam, e_ooc, e_drop;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int want5, want10, dp5, dp10, di5, di10, nxt;
        bit sensed;
        if (!rst) begin
            m_p5 = 0; m_p10 = 0; m_i5 = INV; m_i10 = INV;
            m_activity = 0; m_coin = 0; m_since = 0;
            e_ej5 = 0; e_ej10 = 0; e_busy = 0; e_jam = 0; e_ooc = 0; e_drop = 0;
            return;
        end
        want5 = int'(change_5C); want10 = int'(change_10C);
        dp5 = 0; dp10 = 0; di5 = 0; di10 = 0;
        nxt = m_activity;
        e_ooc = 0;
        case (m_activity)
            0: begin
                if (m_p10 > 0 && m_i10 > 0) begin
                    nxt = 1; m_coin = 10; m_since = 0;
                end else if (m_p10 > 0 && m_i5 >= 2) begin
                    dp10 = 1; want5 += 2;
                end else if (m_p5 > 0 && m_i5 > 0) begin
                    nxt = 1; m_coin = 5; m_since = 0;
                end else begin
                    e_ooc = (m_p5 + m_p10 > 0) ? 1 : 0;
                end
            end
            1: begin
                sensed = (m_coin == 10) ? coin_sensed_10C : coin_sensed_5C;
                if (sensed) begin
                    if (m_coin == 10) begin dp10 = 1; di10 = 1; end
                    else begin dp5 = 1; di5 = 1; end
                    nxt = 2;
                end else begin
                    m_since++;
                    if (m_since >= TO) nxt = 3;
                end
            end
            2: nxt = 0;
            default: if (jam_clear) nxt = 0;
        endcase
        if (refill_5C) m_i5 = int'(refill_count);
        else if (di5 == 1 && m_i5 > 0) m_i5--;
        if (refill_10C) m_i10 = int'(refill_count);
        else if (di10 == 1 && m_i10 > 0) m_i10--;
        m_p5  = m_p5 + want5 - dp5;
        m_p10 = m_p10 + want10 - dp10;
        e_drop = (m_p5 > 15 || m_p10 > 15) ? 1 : 0;
        if (m_p5 > 15) m_p5 = 15;
        if (m_p10 > 15) m_p10 = 15;
        m_activity = nxt;
        e_ej5  = (nxt == 1 && m_coin == 5) ? 1 : 0;
        e_ej10 = (nxt == 1 && m_coin == 10) ? 1 : 0;
        e_jam  = (nxt == 3) ? 1 : 0;
        e_busy = (nxt != 0 || m_p5 + m_p10 > 0) ? 1 : 0;
    endtask

    task automatic compare_all();
        chk("eject_5C", int'(eject_5C), e_ej5);
        chk("eject_10C", int'(eject_10C), e_ej10);
        chk("busy", int'(busy), e_busy);
        chk("jam", int'(jam), e_jam);
        chk("out_of_change", int'(out_of_change), e_ooc);
        chk("req_drop", int'(req_drop), e_drop);
        chk("one_eject", int'(eject_5C & eject_10C), 0);
    endtask

    // One clock: compare on the falling edge, advance the model on the rising edge, clear pulses.
    task automatic tick();
        @(negedge clk);
        if (chk_en) compare_all();
        @(posedge clk);
        model_step();
        #1;
        change_5C = 0; change_10C = 0; coin_sensed_5C = 0; coin_sensed_10C = 0;
        refill_5C = 0; refill_10C = 0; jam_clear = 0;
    endtask

    task automatic do_reset();
        rst = 0;
        tick();
        rst = 1;
        chk_en = 1;
    endtask

    // Sense each coin on its first eject cycle; count coins of each kind and note the first one.
    task automatic serve(input int n, output int n5, output int n10, output int first);
        n5 = 0; n10 = 0; first = 0;
        for (int i = 0; i < n; i++) begin
            coin_sensed_5C  = eject_5C;
            coin_sensed_10C = eject_10C;
            if (eject_5C) begin n5++; if (first == 0) first = 5; end
            if (eject_10C) begin n10++; if (first == 0) first = 10; end
            tick();
        end
    endtask

    int cnt, n5, n10, first, drops;

    initial begin
        rst = 0; change_5C = 0; change_10C = 0; coin_sensed_5C = 0; coin_sensed_10C = 0;
        refill_5C = 0; refill_10C = 0; refill_count = '0; jam_clear = 0;

        do_reset();
        chk("rst_eject_5C", int'(eject_5C), 0);
        chk("rst_eject_10C", int'(eject_10C), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_jam", int'(jam), 0);
        chk("rst_ooc", int'(out_of_change), 0);
        chk("rst_req_drop", int'(req_drop), 0);

        // Single 10c coin, sensed on the third eject cycle.
        change_10C = 1; tick();
        tick();
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cnt += int'(eject_10C);
            if (i == 3) chk("gap_busy", int'(busy), 1);
            coin_sensed_10C = (i == 2);
            tick();
        end
        chk("single_eject_cycles", cnt, 3);
        chk("single_busy_after", int'(busy), 0);
        chk("model_inv10_single", m_i10, 19);
        chk("model_pend10_single", m_p10, 0);

        // Reset in the middle of an eject.
        change_10C = 1; tick();
        tick();
        chk("pre_reset_eject", int'(eject_10C), 1);
        do_reset();
        chk("post_reset_eject", int'(eject_10C), 0);
        chk("post_reset_busy", int'(busy), 0);

        // Both denominations requested together: 10c first.
        do_reset();
        change_5C = 1; change_10C = 1; tick();
        serve(20, n5, n10, first);
        chk("both_first", first, 10);
        chk("both_n5", n5, 1);
        chk("both_n10", n10, 1);
        chk("model_both_inv5", m_i5, 19);
        chk("model_both_inv10", m_i10, 19);

        // Substitution with an empty 10c tube.
        do_reset();
        refill_10C = 1; refill_count = 8'd0; tick();
        change_10C = 1; tick();
        serve(30, n5, n10, first);
        chk("subst_n5", n5, 2);
        chk("subst_n10", n10, 0);
        chk("model_subst_inv5", m_i5, 18);
        chk("subst_busy_after", int'(busy), 0);

        // Timeout into jam, requests piling up while jammed, then recovery.
        do_reset();
        change_10C = 1; tick();
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (jam) break;
            cnt += int'(eject_10C);
            tick();
        end
        chk("timeout_eject_cycles", cnt, TO);
        chk("timeout_jam", int'(jam), 1);
        chk("model_jam_pend10", m_p10, 1);
        drops = 0;
        for (int i = 0; i < 19; i++) begin
            drops += int'(req_drop);
            change_5C = (i < 16);
            tick();
        end
        chk("jam_drop_pulses", drops, 1);
        chk("jam_still", int'(jam), 1);
        chk("model_jam_pend5", m_p5, 15);
        jam_clear = 1; tick();
        chk("jam_cleared", int'(jam), 0);
        serve(80, n5, n10, first);
        chk("recover_first", first, 10);
        chk("recover_n5", n5, 15);
        chk("recover_busy", int'(busy), 0);
        chk("model_recover_inv5", m_i5, 5);

        // Empty hopper, then a 5c refill lets the request through.
        do_reset();
        refill_5C = 1; refill_10C = 1; refill_count = 8'd0; tick();
        change_5C = 1; tick();
        tick();
        chk("ooc_high", int'(out_of_change), 1);
        chk("ooc_no_eject", int'(eject_5C | eject_10C), 0);
        refill_5C = 1; refill_count = 8'd5; tick();
        serve(10, n5, n10, first);
        chk("ooc_refill_n5", n5, 1);
        chk("ooc_low_after", int'(out_of_change), 0);
        chk("model_ooc_inv5", m_i5, 4);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            change_5C  = ($urandom_range(0, 5) == 0);
            change_10C = ($urandom_range(0, 5) == 0);
            coin_sensed_5C  = eject_5C  ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            coin_sensed_10C = eject_10C ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            refill_5C  = ($urandom_range(0, 59) == 0);
            refill_10C = ($urandom_range(0, 59) == 0);
            refill_count = 8'($urandom_range(0, 25));
            jam_clear = jam ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
            rst = !($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
